// File: rtl/perf_pkg.sv
// Shared types and constants for the perf_counter_bank event-counter slice.
// Build option: PERF_SATURATE_EN selects saturating counters instead of wrapping ones.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } perfState_e;

    localparam int DEF_NUM_EVENTS = 8;
    localparam int DEF_CNT_WIDTH  = 32;
    localparam int DEF_SEL_WIDTH  = 5;

    // The cycle counter occupies the slot just past the last event channel.
    function automatic int cycleSlot(input int numEvents);
        return numEvents;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with sticky overflow flag.
// PERF_SATURATE_EN defined: hold at all-ones on overflow; otherwise wrap to zero.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 run,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cntNext,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 ovf_r;
    logic                 ovfNext_s;

    // Next count/flag; the top also snapshots cntNext so shadows include this cycle's event.
    always_comb begin
        cntNext   = cnt_r;
        ovfNext_s = ovf_r;
        if (clr) begin
            cntNext   = '0;
            ovfNext_s = 1'b0;
        end else if (run && inc) begin
            if (&cnt_r) begin
                ovfNext_s = 1'b1;
`ifdef PERF_SATURATE_EN
                cntNext   = cnt_r;
`else
                cntNext   = '0;
`endif
            end else begin
                cntNext   = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                ovfNext_s = ovf_r;
            end
        end else begin
            cntNext   = cnt_r;
            ovfNext_s = ovf_r;
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            cnt_r <= cntNext;
            ovf_r <= ovfNext_s;
        end
    end

    assign ovf = ovf_r;

endmodule

// File: rtl/perf_counter_bank.sv
// Event-counter bank: run-control FSM, NUM_EVENTS+1 counter cells, atomic snapshot, registered readback.
// Build option: PERF_SATURATE_EN (passed through to perf_counter_cell).
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = DEF_NUM_EVENTS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  halt,
    input  logic                  clear,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  snap_req,
    output logic                  snap_ack,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [NUM_EVENTS:0]   ovf,
    output logic [1:0]            state_o
);

    localparam int CYC_SLOT = cycleSlot(NUM_EVENTS);
    localparam int NSLOT    = NUM_EVENTS + 1;

    perfState_e                      state_r;
    perfState_e                      stateNext_s;
    logic                            runEn_s;
    logic [NSLOT-1:0]                incVec_s;
    logic [NSLOT-1:0][CNT_WIDTH-1:0] cntNext_s;
    logic [CNT_WIDTH-1:0]            shadow_r [NSLOT];
    logic [CNT_WIDTH-1:0]            rdMux_s;
    logic [CNT_WIDTH-1:0]            rdData_r;
    logic                            snapAck_r;

    // Run-control next state; clear dominates every state.
    always_comb begin
        stateNext_s = state_r;
        if (clear) begin
            stateNext_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   stateNext_s = enable ? ST_RUN : ST_IDLE;
                ST_RUN:    stateNext_s = halt ? ST_FROZEN : ST_RUN;
                ST_FROZEN: stateNext_s = ST_FROZEN;
                default:   stateNext_s = ST_IDLE;
            endcase
        end
    end

    // Run-control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    assign runEn_s  = (state_r == ST_RUN);
    assign incVec_s = {1'b1, event_in};

    genvar g;
    generate
        for (g = 0; g < NSLOT; g++) begin : gCell
            perf_counter_cell #(.CNT_WIDTH(CNT_WIDTH)) uCell (
                .clk     (clk),
                .rst     (rst),
                .clr     (clear),
                .run     (runEn_s),
                .inc     (incVec_s[g]),
                .cntNext (cntNext_s[g]),
                .ovf     (ovf[g])
            );
        end
    endgenerate

    // Shadows load the counters' next values so a snapshot includes the request cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSLOT; i++) begin
            if (rst || clear) begin
                shadow_r[i] <= '0;
            end else if (snap_req) begin
                shadow_r[i] <= cntNext_s[i];
            end else begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    // Snapshot acknowledge, one cycle after each request.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapAck_r <= 1'b0;
        end else begin
            snapAck_r <= snap_req;
        end
    end

    // A reset arriving while an ack is in flight suppresses it.
    assign snap_ack = snapAck_r & ~rst;

    // Readback mux; out-of-range selects match nothing and read as zero.
    always_comb begin
        rdMux_s = '0;
        for (int i = 0; i < NSLOT; i++) begin
            rdMux_s = rdMux_s | ((rd_sel == SEL_WIDTH'(i)) ? shadow_r[i] : '0);
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_r <= '0;
        end else begin
            rdData_r <= rdMux_s;
        end
    end

    assign rd_data = rdData_r;
    assign state_o = state_r;

    // CYC_SLOT documents where the free-running cycle counter lives in incVec_s.
    if (CYC_SLOT != NUM_EVENTS) begin : gSlotCheck
        $error("cycle slot must equal NUM_EVENTS");
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: a behavioural model keeps true event totals,
// expectations are queued per cycle and a monitor compares them on the falling edge.
module tb_perf_counter_bank;

    localparam int    NE   = 8;
    localparam int    CW   = 8;
    localparam int    SW   = 5;
    localparam longint MAXV = 255;

    localparam int K_ACK = 0, K_STATE = 1, K_OVF = 2, K_RD = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          halt = 1'b0;
    logic          clear = 1'b0;
    logic [NE-1:0] event_in = '0;
    logic          snap_req = 1'b0;
    logic          snap_ack;
    logic [SW-1:0] rd_sel = '0;
    logic [CW-1:0] rd_data;
    logic [NE:0]   ovf;
    logic [1:0]    state_o;

    perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .halt(halt), .clear(clear),
        .event_in(event_in), .snap_req(snap_req), .snap_ack(snap_ack),
        .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     cyc;
        int     kind;
        int     idx;
        longint exp;
    } exp_t;

    exp_t   q[$];
    int     cyc = 0;
    int     nCompared = 0;
    int     nMismatch = 0;

    int     mState = 0;           // 0 idle, 1 counting, 2 frozen
    longint tot [NE+1];           // true number of increments since last clear
    longint shadowM [NE+1];       // value software would read back

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint shown(input longint t);
`ifdef PERF_SATURATE_EN
        return (t > MAXV) ? MAXV : t;
`else
        return t % (MAXV + 1);
`endif
    endfunction

    function automatic longint ovfWord();
        longint w = 0;
        for (int i = 0; i <= NE; i++) if (tot[i] > MAXV) w = w | (longint'(1) << i);
        return w;
    endfunction

    function automatic string kindName(input int k);
        case (k)
            K_ACK:   return "snap_ack";
            K_STATE: return "state_o";
            K_OVF:   return "ovf";
            default: return "rd_data";
        endcase
    endfunction

    task automatic push(input int c, input int k, input int idx, input longint e);
        exp_t x;
        x.cyc = c; x.kind = k; x.idx = idx; x.exp = e;
        q.push_back(x);
    endtask

    // Apply current inputs to the model, queue what the DUT must show after the edge, advance.
    task automatic step();
        int     nc = cyc + 1;
        longint rdExp;
        if (rst) begin
            for (int j = 0; j < q.size(); j++)
                if (q[j].cyc == cyc && q[j].kind == K_ACK) q[j].exp = 0;
        end
        rdExp = (rst || rd_sel > NE) ? 0 : shadowM[rd_sel];
        if (rst || clear) begin
            for (int i = 0; i <= NE; i++) begin tot[i] = 0; shadowM[i] = 0; end
            mState = 0;
        end else begin
            if (mState == 1) begin
                tot[NE] += 1;
                for (int i = 0; i < NE; i++) tot[i] += event_in[i];
            end
            if (mState == 0 && enable) mState = 1;
            else if (mState == 1 && halt) mState = 2;
            if (snap_req) for (int i = 0; i <= NE; i++) shadowM[i] = shown(tot[i]);
        end
        push(nc, K_ACK, 0, (snap_req && !rst) ? 1 : 0);
        push(nc, K_STATE, 0, mState);
        push(nc, K_OVF, 0, ovfWord());
        push(nc, K_RD, int'(rd_sel), rdExp);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.kind)
                K_ACK:   act = {63'd0, snap_ack};
                K_STATE: act = {62'd0, state_o};
                K_OVF:   act = {55'd0, ovf};
                default: act = {56'd0, rd_data};
            endcase
            nCompared++;
            if (act !== 64'(e.exp)) begin
                nMismatch++;
                $display("FAIL %s cyc=%0d sel=%0d: got %0h expected %0h",
                         kindName(e.kind), e.cyc, e.idx, act, e.exp);
            end
        end
    end

    initial begin
        for (int i = 0; i <= NE; i++) begin tot[i] = 0; shadowM[i] = 0; end
        step(); step();
        rst = 1'b0; step();

        // Ten events on channel 0, then snapshot and read back.
        enable = 1'b1; step(); enable = 1'b0;
        event_in = 8'h01; repeat (10) step();
        event_in = 8'h00; snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 5'd0; step();
        rd_sel = 5'(NE); step();
        rd_sel = 5'(NE + 1); step();

        // Halt with a same-cycle event on channel 3, then ignored events and a frozen snapshot.
        event_in = 8'h08; halt = 1'b1; step(); halt = 1'b0;
        event_in = 8'hFF; repeat (5) step();
        event_in = 8'h00; snap_req = 1'b1; step(); snap_req = 1'b0;
        for (int s = 0; s <= NE + 1; s++) begin rd_sel = 5'(s); step(); end

        // 256+ increments on channel 1 to exercise overflow.
        clear = 1'b1; step(); clear = 1'b0;
        enable = 1'b1; step(); enable = 1'b0;
        event_in = 8'h02; repeat (256) step();
        event_in = 8'h00; snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 5'd1; step(); step();

        // clear wins over all-ones events and a snapshot in the same cycle.
        event_in = 8'hFF; clear = 1'b1; snap_req = 1'b1; step();
        clear = 1'b0; snap_req = 1'b0; event_in = 8'h00;
        for (int s = 0; s <= NE; s++) begin rd_sel = 5'(s); step(); end

        // Back-to-back snapshots while counting.
        enable = 1'b1; step(); enable = 1'b0;
        event_in = 8'h5A; snap_req = 1'b1; repeat (3) step(); snap_req = 1'b0;
        rd_sel = 5'd1; step(); step();

        // Reset the cycle after a snapshot request suppresses the ack.
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; event_in = 8'h00; step();

        // Randomised traffic.
        repeat (600) begin
            rst      = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 59) == 0);
            enable   = ($urandom_range(0, 9) == 0);
            halt     = ($urandom_range(0, 79) == 0);
            snap_req = ($urandom_range(0, 5) == 0);
            event_in = NE'($urandom);
            rd_sel   = SW'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; clear = 1'b0; enable = 1'b0; halt = 1'b0; snap_req = 1'b0; event_in = '0;
        repeat (3) step();
        @(negedge clk); #1;

        nCompared++;
        if (q.size() != 0) begin
            nMismatch++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
